// File: rtl/memory_responder.sv
// Word-organised RAM plus a small MMIO window (TOHOST mailbox, cycle counter,
// byte console) acting as responder on a unified instruction/data bus.
module memory_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_data_out,
  input  logic        memory_write_enable,
  output logic [31:0] memory_data_in,
  output logic        halt,
  output logic [31:0] tohost_value,
  output logic        bus_error,
  output logic        console_valid,
  output logic [7:0]  console_byte
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_RAM,
    SRC_MMIO
  } rd_src_t;

  logic [31:0] ram [DEPTH_WORDS];

  logic [29:0]   word_idx;
  logic [29:0]   mmio_off;
  logic [AW-1:0] ram_idx;
  logic          hit_ram;
  logic          hit_tohost;
  logic          hit_cycle;
  logic          hit_console;
  logic          unmapped;
  logic          wr_ok;
  logic [31:0]   cycle;
  logic [31:0]   mmio_rd;
  logic [31:0]   ram_q_p1;
  logic [31:0]   mmio_q_p1;
  rd_src_t       src_p1;
  logic          addr_lsbs_unused;

  // Byte lanes do not exist; the two low address bits are deliberately dropped.
  assign addr_lsbs_unused = ^memory_address[1:0];

  assign word_idx    = memory_address[31:2];
  assign mmio_off    = word_idx - MMIO_BASE[31:2];
  assign ram_idx     = memory_address[AW+1:2];
  assign hit_ram     = (memory_address[31:AW+2] == '0);
  assign hit_tohost  = !hit_ram && (mmio_off == 30'd0);
  assign hit_cycle   = !hit_ram && (mmio_off == 30'd1);
  assign hit_console = !hit_ram && (mmio_off == 30'd2);
  assign unmapped    = !(hit_ram || hit_tohost || hit_cycle || hit_console);
  assign wr_ok       = memory_write_enable && !halt && !reset;

  always_comb begin
    mmio_rd = 32'hDEAD_BEEF;
    if (hit_tohost)       mmio_rd = tohost_value;
    else if (hit_cycle)   mmio_rd = cycle;
    else if (hit_console) mmio_rd = 32'h0;
  end

  // Stage p0 -> p1: RAM access is read-first, so a same-cycle write is seen next access.
  always_ff @(posedge clk) begin
    if (wr_ok && hit_ram) ram[ram_idx] <= memory_data_out;
    ram_q_p1  <= ram[ram_idx];
    mmio_q_p1 <= mmio_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_p1        <= SRC_ZERO;
      halt          <= 1'b0;
      tohost_value  <= 32'h0;
      bus_error     <= 1'b0;
      console_valid <= 1'b0;
      console_byte  <= 8'h0;
      cycle         <= 32'h0;
    end else begin
      src_p1        <= hit_ram ? SRC_RAM : SRC_MMIO;
      console_valid <= wr_ok && hit_console;
      if (wr_ok && hit_console) console_byte <= memory_data_out[7:0];
      if (wr_ok && hit_tohost) begin
        tohost_value <= memory_data_out;
        halt         <= 1'b1;
      end
      if (unmapped) bus_error <= 1'b1;
      if (!halt) cycle <= cycle + 32'd1;
    end
  end

  always_comb begin
    memory_data_in = 32'h0;
    case (src_p1)
      SRC_RAM:  memory_data_in = ram_q_p1;
      SRC_MMIO: memory_data_in = mmio_q_p1;
      default:  memory_data_in = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_memory_responder.sv
// Randomised bench for memory_responder with a behavioural reference model and
// a few hand-computed directed expectations.
module tb_memory_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] MB    = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memory_address;
  logic [31:0] memory_data_out;
  logic        memory_write_enable;
  logic [31:0] memory_data_in;
  logic        halt;
  logic [31:0] tohost_value;
  logic        bus_error;
  logic        console_valid;
  logic [7:0]  console_byte;

  int vectors     = 0;
  int miscompares = 0;

  memory_responder #(
    .DEPTH_WORDS(DEPTH),
    .INIT_FILE(""),
    .MMIO_BASE(MB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .memory_address(memory_address),
    .memory_data_out(memory_data_out),
    .memory_write_enable(memory_write_enable),
    .memory_data_in(memory_data_in),
    .halt(halt),
    .tohost_value(tohost_value),
    .bus_error(bus_error),
    .console_valid(console_valid),
    .console_byte(console_byte)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mem [DEPTH];
  bit          known [DEPTH];
  bit          m_valid = 0;
  bit          m_after_rst = 0;
  bit          m_rd_known = 0;
  logic [31:0] m_rd = 0;
  logic [31:0] m_tohost = 0;
  logic [31:0] m_cycle = 0;
  bit          m_halt = 0;
  bit          m_berr = 0;
  bit          m_cv = 0;
  logic [7:0]  m_cb = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
  end

  always @(posedge clk) begin
    logic [31:0] a;
    logic [31:0] off;
    bit          was_halted;
    bit          wr;
    if (reset) begin
      m_valid = 1; m_after_rst = 1; m_rd_known = 1; m_rd = 0;
      m_tohost = 0; m_cycle = 0; m_halt = 0; m_berr = 0; m_cv = 0; m_cb = 0;
    end else if (m_valid) begin
      a = memory_address;
      off = a - MB;
      was_halted = m_halt;
      wr = memory_write_enable && !was_halted;
      m_after_rst = 0;
      m_rd_known = 1;
      m_cv = 0;
      if (a < 4 * DEPTH) begin
        m_rd = mem[a / 4];
        m_rd_known = known[a / 4];
        if (wr) begin
          mem[a / 4] = memory_data_out;
          known[a / 4] = 1;
        end
      end else if (a >= MB && off < 4) begin
        m_rd = m_tohost;
        if (wr) begin
          m_tohost = memory_data_out;
          m_halt = 1;
        end
      end else if (a >= MB && off < 8) begin
        m_rd = m_cycle;
      end else if (a >= MB && off < 12) begin
        m_rd = 0;
        if (wr) begin
          m_cv = 1;
          m_cb = memory_data_out[7:0];
        end
      end else begin
        m_rd = 32'hDEAD_BEEF;
        m_berr = 1;
      end
      if (!was_halted) m_cycle = m_cycle + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      if (m_rd_known) chk("model_rdata", memory_data_in, m_rd);
      chk("model_halt", {31'h0, halt}, {31'h0, m_halt});
      chk("model_tohost", tohost_value, m_tohost);
      chk("model_bus_error", {31'h0, bus_error}, {31'h0, m_berr});
      chk("model_console_valid", {31'h0, console_valid}, {31'h0, m_cv});
      if (m_cv || m_after_rst) chk("model_console_byte", {24'h0, console_byte}, {24'h0, m_cb});
    end
  end

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we, input logic r);
    memory_address      = a;
    memory_data_out     = d;
    memory_write_enable = we;
    reset               = r;
    @(negedge clk);
  endtask

  task automatic rand_cycle(input int mode);
    logic [31:0] a;
    logic        we;
    logic        r;
    int          k;
    int          lo;
    lo = (mode == 2) ? 0 : 9;
    k  = $urandom_range(0, 9);
    we = 1'($urandom_range(0, 1));
    r  = 1'b0;
    a  = 32'($urandom_range(lo, DEPTH - 1)) * 4 + 32'($urandom_range(0, 3));
    case (k)
      4: begin
        a = MB + 32'($urandom_range(0, 3));
        if (mode == 0) we = 1'b0;
      end
      5: a = MB + 32'd4 + 32'($urandom_range(0, 3));
      6, 7: a = MB + 32'd8 + 32'($urandom_range(0, 3));
      8: if (mode != 0) begin
        case ($urandom_range(0, 3))
          0: a = 32'(4 * DEPTH);
          1: a = MB + 32'd12;
          2: a = 32'h2000_0000;
          default: a = $urandom;
        endcase
      end
      9: a = 32'((DEPTH - 1) * 4);
      default: ;
    endcase
    if (mode == 2 && $urandom_range(0, 49) == 0) r = 1'b1;
    step(a, $urandom, we, r);
  endtask

  initial begin
    // Reset values and first CYCLE reads
    step(32'h0, 32'h0, 1'b1, 1'b1);
    chk("rst_rdata", memory_data_in, 32'h0);
    chk("rst_halt", {31'h0, halt}, 32'h0);
    chk("rst_tohost", tohost_value, 32'h0);
    chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
    chk("rst_console", {23'h0, console_valid, console_byte}, 32'h0);
    step(MB + 32'd4, 32'h0, 1'b0, 1'b0);
    chk("cycle_first", memory_data_in, 32'h0);
    step(MB + 32'd4, 32'h0, 1'b0, 1'b0);
    chk("cycle_second", memory_data_in, 32'h1);

    // Plain write/readback, low address bits ignored
    step(32'h10, 32'hCAFE_F00D, 1'b1, 1'b0);
    step(32'h10, 32'h0, 1'b0, 1'b0);
    chk("rd_0x10", memory_data_in, 32'hCAFE_F00D);
    step(32'h13, 32'h0, 1'b0, 1'b0);
    chk("rd_0x13", memory_data_in, 32'hCAFE_F00D);

    // Read-during-write is read-first
    step(32'h20, 32'h1, 1'b1, 1'b0);
    step(32'h20, 32'h2, 1'b1, 1'b0);
    chk("rdw_old", memory_data_in, 32'h1);
    step(32'h20, 32'h0, 1'b0, 1'b0);
    chk("rdw_new", memory_data_in, 32'h2);

    // Back-to-back console writes
    step(MB + 32'd8, 32'h41, 1'b1, 1'b0);
    chk("con_a", {23'h0, console_valid, console_byte}, 32'h141);
    step(MB + 32'd8, 32'h42, 1'b1, 1'b0);
    chk("con_b", {23'h0, console_valid, console_byte}, 32'h142);
    step(MB + 32'd8, 32'h0, 1'b0, 1'b0);
    chk("con_read", memory_data_in, 32'h0);
    chk("con_idle", {31'h0, console_valid}, 32'h0);

    for (int i = 0; i < 1500; i++) rand_cycle(0);

    // Unmapped access and sticky bus_error
    step(32'h2000_0000, 32'h0, 1'b0, 1'b0);
    chk("unmapped_rd", memory_data_in, 32'hDEAD_BEEF);
    chk("unmapped_err", {31'h0, bus_error}, 32'h1);
    step(32'h10, 32'h0, 1'b0, 1'b0);
    chk("err_sticky", {31'h0, bus_error}, 32'h1);

    // TOHOST halts; later writes ignored
    step(MB, 32'h1, 1'b1, 1'b0);
    chk("tohost_halt", {31'h0, halt}, 32'h1);
    chk("tohost_val", tohost_value, 32'h1);
    step(32'h0, 32'h5, 1'b1, 1'b0);
    step(MB, 32'h2, 1'b1, 1'b0);
    chk("tohost_ignored", tohost_value, 32'h1);
    step(MB + 32'd4, 32'h0, 1'b0, 1'b0);
    step(MB + 32'd4, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 500; i++) rand_cycle(1);

    // Mid-run reset keeps RAM
    step(32'h10, 32'h77, 1'b1, 1'b1);
    chk("rst2_halt", {31'h0, halt}, 32'h0);
    chk("rst2_bus_error", {31'h0, bus_error}, 32'h0);
    chk("rst2_rdata", memory_data_in, 32'h0);
    step(MB + 32'd4, 32'h0, 1'b0, 1'b0);
    chk("rst2_cycle", memory_data_in, 32'h0);
    step(32'h10, 32'h0, 1'b0, 1'b0);
    chk("rst2_ram_kept", memory_data_in, 32'hCAFE_F00D);

    for (int i = 0; i < 3000; i++) rand_cycle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
